// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_pkg
// Brief    : Opcodes, control encodings and ID/EX control struct for decode.
// Revision : 1.0
// ============================================================================
package decode_stage_pkg;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef struct packed {
    logic        reg_write;
    result_src_t result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    alu_ctrl_t   alu_control;
    logic        alu_src;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t c_ctrl_bubble = '0;

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_if
// Brief    : D-stage inputs and registered E-stage outputs of the decode stage.
//            FlushE exists only when DECODE_FLUSH_EN is defined.
// Revision : 1.0
// ============================================================================
interface decode_stage_if;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
`ifdef DECODE_FLUSH_EN
  logic        FlushE;
`endif
  logic        RegWriteE;
  logic        MemWriteE;
  logic        JumpE;
  logic        BranchE;
  logic        ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [4:0]  RdE;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] ImmExtE;

  // master: the fetch/hazard side feeding decode; slave: the decode stage
  modport master (
    output InstrD, PCD, PCPlus4D, RD1D, RD2D,
`ifdef DECODE_FLUSH_EN
    output FlushE,
`endif
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
    input  ALUControlE, RdE, PCE, PCPlus4E, RD1E, RD2E, ImmExtE
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, RD1D, RD2D,
`ifdef DECODE_FLUSH_EN
    input  FlushE,
`endif
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
    output ALUControlE, RdE, PCE, PCPlus4E, RD1E, RD2E, ImmExtE
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage_imm_extend.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend
// Brief    : Sign-extends the I/S/B/J immediate selected by imm_src.
// Revision : 1.0
// ============================================================================
module imm_extend
  import decode_stage_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_src_t    imm_src,
  output logic [31:0] imm_ext
);

  always_comb begin
    imm_ext = '0;
    case (imm_src)
      IMM_I:   imm_ext = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_ext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : Decode (main + ALU decoder, immediate extend) and ID/EX register.
//            Define DECODE_FLUSH_EN to add the FlushE bubble-insert input.
// Revision : 1.0
// ============================================================================
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  decode_stage_if.slave  bus
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_reg_write;
  imm_src_t    w_imm_src;
  logic        w_alu_src;
  logic        w_mem_write;
  result_src_t w_result_src;
  logic        w_branch;
  alu_op_t     w_alu_op;
  logic        w_jump;
  alu_ctrl_t   w_alu_control;
  logic [31:0] w_imm_ext;
  logic        w_flush;
  id_ex_ctrl_t w_ctrl;

  id_ex_ctrl_t r_ctrl;
  logic [4:0]  r_rd;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus4;
  logic [31:0] r_rd1;
  logic [31:0] r_rd2;
  logic [31:0] r_imm_ext;

  assign w_opcode = bus.InstrD[6:0];
  assign w_funct3 = bus.InstrD[14:12];

  always_comb begin
    w_reg_write  = 1'b0;
    w_imm_src    = IMM_I;
    w_alu_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_result_src = RES_ALU;
    w_branch     = 1'b0;
    w_alu_op     = ALUOP_ADD;
    w_jump       = 1'b0;
    case (w_opcode)
      c_op_load: begin
        w_reg_write  = 1'b1;
        w_alu_src    = 1'b1;
        w_result_src = RES_MEM;
      end
      c_op_store: begin
        w_imm_src   = IMM_S;
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      c_op_rtype: begin
        w_reg_write = 1'b1;
        w_alu_op    = ALUOP_FUNCT;
      end
      c_op_branch: begin
        w_imm_src = IMM_B;
        w_branch  = 1'b1;
        w_alu_op  = ALUOP_SUB;
      end
      c_op_itype: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_op    = ALUOP_FUNCT;
      end
      c_op_jal: begin
        w_reg_write  = 1'b1;
        w_imm_src    = IMM_J;
        w_result_src = RES_PC4;
        w_jump       = 1'b1;
      end
      default: ;
    endcase
  end

  // Subtract only for R-type with funct7[5]; I-type addi may have bit 30 set
  always_comb begin
    w_alu_control = ALU_ADD;
    case (w_alu_op)
      ALUOP_SUB: w_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (w_funct3)
          3'b000:  w_alu_control = (w_opcode[5] & bus.InstrD[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  w_alu_control = ALU_SLT;
          3'b110:  w_alu_control = ALU_OR;
          3'b111:  w_alu_control = ALU_AND;
          default: w_alu_control = ALU_ADD;
        endcase
      end
      default: w_alu_control = ALU_ADD;
    endcase
  end

  imm_extend u_imm_extend (
    .instr   (bus.InstrD[31:7]),
    .imm_src (w_imm_src),
    .imm_ext (w_imm_ext)
  );

  assign w_ctrl = '{
    reg_write:   w_reg_write,
    result_src:  w_result_src,
    mem_write:   w_mem_write,
    jump:        w_jump,
    branch:      w_branch,
    alu_control: w_alu_control,
    alu_src:     w_alu_src
  };

`ifdef DECODE_FLUSH_EN
  assign w_flush = bus.FlushE;
`else
  assign w_flush = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_ctrl     <= c_ctrl_bubble;
      r_rd       <= '0;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm_ext  <= '0;
    end else begin
      r_ctrl     <= w_ctrl;
      r_rd       <= bus.InstrD[11:7];
      r_pc       <= bus.PCD;
      r_pc_plus4 <= bus.PCPlus4D;
      r_rd1      <= bus.RD1D;
      r_rd2      <= bus.RD2D;
      r_imm_ext  <= w_imm_ext;
    end
  end

  assign bus.RegWriteE   = r_ctrl.reg_write;
  assign bus.MemWriteE   = r_ctrl.mem_write;
  assign bus.JumpE       = r_ctrl.jump;
  assign bus.BranchE     = r_ctrl.branch;
  assign bus.ALUSrcE     = r_ctrl.alu_src;
  assign bus.ResultSrcE  = r_ctrl.result_src;
  assign bus.ALUControlE = r_ctrl.alu_control;
  assign bus.RdE         = r_rd;
  assign bus.PCE         = r_pc;
  assign bus.PCPlus4E    = r_pc_plus4;
  assign bus.RD1E        = r_rd1;
  assign bus.RD2E        = r_rd2;
  assign bus.ImmExtE     = r_imm_ext;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Directed bench for decode_stage with hand-computed expectations.
// Revision : 1.0
// ============================================================================
module tb_decode_stage;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  decode_stage_if bus ();

  decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_e(input string tag,
                          input logic rw, input logic mw, input logic j,
                          input logic b, input logic as,
                          input logic [1:0] rs, input logic [2:0] ac,
                          input logic [4:0] rd,
                          input logic [31:0] pc, input logic [31:0] rd1,
                          input logic [31:0] rd2, input logic [31:0] imm);
    check({tag, ".RegWriteE"},   32'(bus.RegWriteE),   32'(rw));
    check({tag, ".MemWriteE"},   32'(bus.MemWriteE),   32'(mw));
    check({tag, ".JumpE"},       32'(bus.JumpE),       32'(j));
    check({tag, ".BranchE"},     32'(bus.BranchE),     32'(b));
    check({tag, ".ALUSrcE"},     32'(bus.ALUSrcE),     32'(as));
    check({tag, ".ResultSrcE"},  32'(bus.ResultSrcE),  32'(rs));
    check({tag, ".ALUControlE"}, 32'(bus.ALUControlE), 32'(ac));
    check({tag, ".RdE"},         32'(bus.RdE),         32'(rd));
    check({tag, ".PCE"},         bus.PCE,              pc);
    check({tag, ".PCPlus4E"},    bus.PCPlus4E,         (pc == 32'h0) ? 32'h0 : pc + 32'd4);
    check({tag, ".RD1E"},        bus.RD1E,             rd1);
    check({tag, ".RD2E"},        bus.RD2E,             rd2);
    check({tag, ".ImmExtE"},     bus.ImmExtE,          imm);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rd1, input logic [31:0] rd2);
    bus.InstrD   = instr;
    bus.PCD      = pc;
    bus.PCPlus4D = pc + 32'd4;
    bus.RD1D     = rd1;
    bus.RD2D     = rd2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
`ifdef DECODE_FLUSH_EN
    bus.FlushE = 1'b0;
`endif
    // Reset wins over capture of a live lw
    drive(32'h0080A283, 32'h100, 32'h11111111, 32'h22222222);
    step();
    expect_e("reset", 0, 0, 0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);

    reset = 1'b0;
    step();
    expect_e("lw", 1, 0, 0, 0, 1, 2'b01, 3'b000, 5'd5, 32'h100, 32'h11111111, 32'h22222222, 32'h8);

    drive(32'h402081B3, 32'h104, 32'hAAAA5555, 32'h0F0F0F0F);
    step();
    expect_e("sub", 1, 0, 0, 0, 0, 2'b00, 3'b001, 5'd3, 32'h104, 32'hAAAA5555, 32'h0F0F0F0F, 32'h402);

    drive(32'hFE612E23, 32'h108, 32'h00001000, 32'hDEADBEEF);
    step();
    expect_e("sw", 0, 1, 0, 0, 1, 2'b00, 3'b000, 5'd28, 32'h108, 32'h00001000, 32'hDEADBEEF, 32'hFFFFFFFC);

    drive(32'hFE208CE3, 32'h10C, 32'h5, 32'h5);
    step();
    expect_e("beq", 0, 0, 0, 1, 0, 2'b00, 3'b001, 5'd25, 32'h10C, 32'h5, 32'h5, 32'hFFFFFFF8);

    drive(32'h010000EF, 32'h110, 32'h0, 32'hFFFFFFFF);
    step();
    expect_e("jal", 1, 0, 1, 0, 0, 2'b10, 3'b000, 5'd1, 32'h110, 32'h0, 32'hFFFFFFFF, 32'h10);

    drive(32'hFFF0E113, 32'h114, 32'h12345678, 32'h87654321);
    step();
    expect_e("ori", 1, 0, 0, 0, 1, 2'b00, 3'b011, 5'd2, 32'h114, 32'h12345678, 32'h87654321, 32'hFFFFFFFF);

    drive(32'h009473B3, 32'h118, 32'hF0F0F0F0, 32'h0FF00FF0);
    step();
    expect_e("and", 1, 0, 0, 0, 0, 2'b00, 3'b010, 5'd7, 32'h118, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h9);

    drive(32'h0020A1B3, 32'h11C, 32'h1, 32'h2);
    step();
    expect_e("slt", 1, 0, 0, 0, 0, 2'b00, 3'b101, 5'd3, 32'h11C, 32'h1, 32'h2, 32'h2);

    // addi with imm bit 10 set: bit 30 high but not R-type, so add
    drive(32'h40000093, 32'h120, 32'h0, 32'h0);
    step();
    expect_e("addi_b30", 1, 0, 0, 0, 1, 2'b00, 3'b000, 5'd1, 32'h120, 32'h0, 32'h0, 32'h400);

    drive(32'hFFF00073, 32'h124, 32'hCAFEF00D, 32'h0BADC0DE);
    step();
    expect_e("illegal", 0, 0, 0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h124, 32'hCAFEF00D, 32'h0BADC0DE, 32'hFFFFFFFF);

`ifdef DECODE_FLUSH_EN
    drive(32'h0080A283, 32'h100, 32'h11111111, 32'h22222222);
    step();
    expect_e("lw2", 1, 0, 0, 0, 1, 2'b01, 3'b000, 5'd5, 32'h100, 32'h11111111, 32'h22222222, 32'h8);
    bus.FlushE = 1'b1;
    drive(32'h402081B3, 32'h104, 32'hAAAA5555, 32'h0F0F0F0F);
    step();
    expect_e("flush", 0, 0, 0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    bus.FlushE = 1'b0;
    step();
    expect_e("post_flush", 1, 0, 0, 0, 0, 2'b00, 3'b001, 5'd3, 32'h104, 32'hAAAA5555, 32'h0F0F0F0F, 32'h402);
`endif

    // Mid-stream single-cycle reset, then immediate resume
    reset = 1'b1;
    drive(32'h010000EF, 32'h200, 32'h33333333, 32'h44444444);
    step();
    expect_e("mid_reset", 0, 0, 0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    reset = 1'b0;
    step();
    expect_e("resume", 1, 0, 1, 0, 0, 2'b10, 3'b000, 5'd1, 32'h200, 32'h33333333, 32'h44444444, 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  in  1  rising-edge clock; single clock domain.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 InstrD  in  32  instruction in decode.
REQ-004 PCD  in  32  PC of InstrD.
REQ-005 PCPlus4D  in  32  PCD+4.
REQ-006 RD1D  in  32  rs1 read data from the external register file.
REQ-007 RD2D  in  32  rs2 read data from the external register file.
REQ-008 RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered control bits.
REQ-009 ResultSrcE  out  2  result select: 00 ALU, 01 memory, 10 PC+4.
REQ-010 ALUControlE  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-011 RdE  out  5  registered InstrD[11:7].
REQ-012 PCE, PCPlus4E, RD1E, RD2E, ImmExtE  out  32 each  registered datapath values.
REQ-013 FlushE  in  1  synchronous bubble insert; present only with DECODE_FLUSH_EN.

Function
REQ-014 Main decode by opcode InstrD[6:0], fields RegWrite/ImmSrc/ALUSrc/MemWrite/ResultSrc/Branch/ALUOp/Jump: lw 0000011 = 1/00/1/0/01/0/00/0; sw 0100011 = 0/01/1/1/00/0/00/0; R 0110011 = 1/00/0/0/00/0/10/0; beq 1100011 = 0/10/0/0/00/1/01/0; I-ALU 0010011 = 1/00/1/0/00/0/10/0; jal 1101111 = 1/11/0/0/10/0/00/1.
REQ-015 Any other opcode decodes to all-zero controls (no write, no branch, no jump).
REQ-016 ALU decode: ALUOp 00 -> 000; 01 -> 001; 10 uses funct3 InstrD[14:12]: 000 -> 001 if InstrD[5]&InstrD[30], else 000; 010 -> 101; 110 -> 011; 111 -> 010; other funct3 -> 000; ALUOp 11 -> 000.
REQ-017 Immediate extension, all sign-extended from InstrD[31]: ImmSrc 00 I = InstrD[31:20]; 01 S = {InstrD[31:25], InstrD[11:7]}; 10 B = {InstrD[7], InstrD[30:25], InstrD[11:8], 0}; 11 J = {InstrD[19:12], InstrD[20], InstrD[30:21], 0}.
REQ-018 Decode and extension are combinational; all E outputs register on the rising clk edge, giving one cycle of latency.
REQ-019 With no reset or flush, every rising edge captures the current D-stage values; there is no stall or enable.
REQ-020 PCD, PCPlus4D, RD1D and RD2D pass through to the E outputs unmodified.

Reset
REQ-021 When reset is high at a rising edge, every E output becomes 0 (all control bits, ResultSrcE=00, ALUControlE=000, RdE=0, all 32-bit outputs 0).
REQ-022 Reset has priority over FlushE and over capture; values captured before reset are discarded.
REQ-023 Asserting reset for one cycle is sufficient; capture resumes on the first edge after reset deasserts.

Configuration
REQ-024 When DECODE_FLUSH_EN is defined, FlushE=1 at a rising edge loads the same all-zero values as reset.
REQ-025 When DECODE_FLUSH_EN is undefined, the FlushE port does not exist and behaviour is as defined in REQ-018 to REQ-023.

Structure
REQ-026 A shared package holds: opcode constants; the ImmSrc, ResultSrc, ALUOp and ALUControl encodings; and a packed struct of the ID/EX control fields.
REQ-027 The immediate extender is a separate sub-module named imm_extend; the main decoder, ALU decoder and pipeline register stay inline.

Verification
REQ-028 Reset high for 1 cycle -> all E outputs 0.
REQ-029 InstrD=0x0080A283 (lw x5,8(x1)), PCD=0x100, PCPlus4D=0x104 -> next edge: RegWriteE=1, ALUSrcE=1, ResultSrcE=01, ALUControlE=000, ImmExtE=8, RdE=5, PCE=0x100, PCPlus4E=0x104.
REQ-030 InstrD=0x402081B3 (sub x3,x1,x2) -> ALUControlE=001, RegWriteE=1, ALUSrcE=0, RdE=3.
REQ-031 InstrD=0xFE612E23 (sw x6,-4(x2)) -> MemWriteE=1, RegWriteE=0, ALUSrcE=1, ImmExtE=0xFFFFFFFC.
REQ-032 InstrD=0xFE208CE3 (beq, offset -8) -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8; InstrD=0x010000EF (jal x1,16) -> JumpE=1, ResultSrcE=10, ImmExtE=16, RdE=1.
REQ-033 With DECODE_FLUSH_EN defined: FlushE=1 at the edge after the lw of REQ-029 -> all E outputs 0.
